// File: rtl/battle_pkg.sv
// Shared types and constants for the battle-screen input sequencer.
// Menu states double as the encoding driven on the menu output.
package battle_pkg;

    typedef enum logic [1:0] {
        MAIN  = 2'd0,
        MOVES = 2'd1,
        WAIT  = 2'd2,
        BUSY  = 2'd3
    } menu_t;

    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_DOWN  = 4'd8;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_OK    = 4'd5;
    localparam logic [3:0] KEY_BACK  = 4'd0;

    localparam logic [1:0] ACT_MAIN = 2'b00;
    localparam logic [1:0] ACT_MOVE = 2'b01;

    // Saturating 2x2 cursor step; bit1 = row, bit0 = column.
    function automatic logic [1:0] step_cursor(input logic [1:0] cur, input logic [3:0] key);
        logic [1:0] nxt;
        nxt = cur;
        case (key)
            KEY_UP:    nxt[1] = 1'b0;
            KEY_DOWN:  nxt[1] = 1'b1;
            KEY_LEFT:  nxt[0] = 1'b0;
            KEY_RIGHT: nxt[0] = 1'b1;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Level debouncer: one press event per stable press, re-armed only after
// the key has been stably released.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_held,
    input  logic [3:0] key_code,
    output logic       press_evt,
    output logic [3:0] press_code
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_hi_cnt;
    logic [CW-1:0] r_lo_cnt;
    logic          r_armed;
    logic          r_evt;
    logic [3:0]    r_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
            r_armed  <= 1'b1;
            r_evt    <= 1'b0;
            r_code   <= '0;
        end else begin
            r_evt <= 1'b0;
            if (key_held) begin
                r_lo_cnt <= '0;
                // High samples only accumulate while armed, so a held key fires once.
                if (r_armed) begin
                    if (r_hi_cnt == LAST) begin
                        r_evt    <= 1'b1;
                        r_code   <= key_code;
                        r_armed  <= 1'b0;
                        r_hi_cnt <= '0;
                    end else if (r_hi_cnt != SAT) begin
                        r_hi_cnt <= r_hi_cnt + 1'b1;
                    end
                end
            end else begin
                r_hi_cnt <= '0;
                if (!r_armed) begin
                    if (r_lo_cnt == LAST) begin
                        r_armed  <= 1'b1;
                        r_lo_cnt <= '0;
                    end else if (r_lo_cnt != SAT) begin
                        r_lo_cnt <= r_lo_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign press_evt  = r_evt;
    assign press_code = r_code;

endmodule

// File: rtl/battle_menu_ctrl.sv
// Battle-screen menu sequencer: debounced keys drive a 2x2 cursor through the
// main/move menus and hand one action per turn to the turn logic.
module battle_menu_ctrl
    import battle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_held,
    input  logic [3:0] key_code,
    input  logic       action_ready,
    input  logic       turn_done,
    output logic [1:0] menu,
    output logic [1:0] cursor,
    output logic       action_valid,
    output logic [3:0] action_code
);

    logic       w_evt;
    logic [3:0] w_pcode;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .key_held  (key_held),
        .key_code  (key_code),
        .press_evt (w_evt),
        .press_code(w_pcode)
    );

    menu_t      r_state, w_state;
    logic [1:0] r_cursor, w_cursor;
    logic [3:0] r_code, w_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= MAIN;
            r_cursor <= '0;
            r_code   <= '0;
        end else begin
            r_state  <= w_state;
            r_cursor <= w_cursor;
            r_code   <= w_code;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cursor = r_cursor;
        w_code   = r_code;
        case (r_state)
            MAIN, MOVES: begin
                if (w_evt) begin
                    case (w_pcode)
                        KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT:
                            w_cursor = step_cursor(r_cursor, w_pcode);
                        KEY_OK: begin
                            // FIGHT opens the move menu; every other confirm is an action.
                            if (r_state == MAIN && r_cursor == 2'd0) begin
                                w_state  = MOVES;
                                w_cursor = '0;
                            end else begin
                                w_state = WAIT;
                                w_code  = {(r_state == MOVES) ? ACT_MOVE : ACT_MAIN, r_cursor};
                            end
                        end
                        KEY_BACK: begin
                            if (r_state == MOVES) begin
                                w_state  = MAIN;
                                w_cursor = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (action_ready) w_state = BUSY;
            end
            BUSY: begin
                if (turn_done) begin
                    w_state  = MAIN;
                    w_cursor = '0;
                end
            end
            default: w_state = MAIN;
        endcase
    end

    assign menu         = r_state;
    assign cursor       = r_cursor;
    assign action_valid = (r_state == WAIT);
    assign action_code  = r_code;

endmodule

// File: tb/tb_battle_menu_ctrl.sv
// Directed scenarios plus randomized key/handshake traffic, checked every
// cycle against a sliding-window debounce model and an event-level menu model.
module tb_battle_menu_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_held = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       action_ready = 1'b0;
    logic       turn_done = 1'b0;
    logic [1:0] menu;
    logic [1:0] cursor;
    logic       action_valid;
    logic [3:0] action_code;

    battle_menu_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_held    (key_held),
        .key_code    (key_code),
        .action_ready(action_ready),
        .turn_done   (turn_done),
        .menu        (menu),
        .cursor      (cursor),
        .action_valid(action_valid),
        .action_code (action_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    endtask

    // Reference model state
    bit   hist[$];
    bit   m_armed;
    bit   m_evt;
    int   m_pcode;
    int   m_menu, m_row, m_col, m_code;

    task model_reset();
        hist.delete();
        m_armed = 1; m_evt = 0; m_pcode = 0;
        m_menu = 0; m_row = 0; m_col = 0; m_code = 0;
    endtask

    task model_edge();
        int cur;
        bit all_hi, all_lo, nevt;
        cur = m_row * 2 + m_col;
        case (m_menu)
            0, 1: if (m_evt) begin
                case (m_pcode)
                    2: m_row = 0;
                    8: m_row = 1;
                    4: m_col = 0;
                    6: m_col = 1;
                    5: if (m_menu == 0 && cur == 0) begin
                           m_menu = 1; m_row = 0; m_col = 0;
                       end else begin
                           m_code = (m_menu == 1 ? 4 : 0) + cur;
                           m_menu = 2;
                       end
                    0: if (m_menu == 1) begin m_menu = 0; m_row = 0; m_col = 0; end
                    default: ;
                endcase
            end
            2: if (action_ready) m_menu = 3;
            3: if (turn_done) begin m_menu = 0; m_row = 0; m_col = 0; end
            default: ;
        endcase
        hist.push_back(key_held);
        if (hist.size() > N) void'(hist.pop_front());
        all_hi = (hist.size() == N);
        all_lo = (hist.size() == N);
        foreach (hist[i]) begin
            if (!hist[i]) all_hi = 0;
            if (hist[i])  all_lo = 0;
        end
        nevt = 0;
        if (m_armed && all_hi) begin
            nevt = 1; m_pcode = key_code; m_armed = 0;
        end else if (!m_armed && all_lo) begin
            m_armed = 1;
        end
        m_evt = nevt;
    endtask

    task step();
        @(posedge clk);
        model_edge();
        #1;
        chk("menu", menu, m_menu);
        chk("cursor", cursor, m_row * 2 + m_col);
        chk("action_valid", action_valid, m_menu == 2);
        chk("action_code", action_code, m_code);
        chk("press_evt", dut.w_evt, m_evt);
    endtask

    task press(input logic [3:0] code);
        key_held = 1; key_code = code;
        repeat (N + 1) step();
        key_held = 0;
        repeat (N + 1) step();
    endtask

    int vcnt;
    logic [3:0] codes [8] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd1, 4'hf};
    logic lvl;
    int   len;

    initial begin
        model_reset();
        #3;
        chk("rst_menu", menu, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_valid", action_valid, 0);
        chk("rst_code", action_code, 0);
        @(negedge clk); reset = 0;

        // Bounce: 1,1,0,1,1,1,1 on key 6 -> one event, cursor 0->1
        key_code = 4'd6;
        lvl = 1; key_held = 1; step(); step();
        key_held = 0; step();
        key_held = 1; repeat (4) step();
        chk("bounce_pre", cursor, 0);
        step();
        chk("bounce_cursor", cursor, 1);
        repeat (100) step();
        chk("hold_cursor", cursor, 1);
        key_held = 0; repeat (N + 1) step();

        // Navigation with saturation
        press(4'd6); chk("nav6", cursor, 1);
        press(4'd8); chk("nav8a", cursor, 3);
        press(4'd8); chk("nav8b", cursor, 3);
        press(4'd6); chk("nav6b", cursor, 3);
        press(4'd2); press(4'd4); chk("nav_home", cursor, 0);

        // Fight path
        press(4'd5); chk("fight_menu", menu, 1); chk("fight_cursor", cursor, 0);
        press(4'd8); press(4'd6); press(4'd5);
        chk("move_menu", menu, 2); chk("move_valid", action_valid, 1);
        chk("move_code", action_code, 4'b0111);
        repeat (10) step();
        chk("stall_code", action_code, 4'b0111);

        // Handshake
        action_ready = 1; step(); action_ready = 0;
        chk("busy_menu", menu, 3); chk("busy_valid", action_valid, 0);
        press(4'd5); chk("busy_key", menu, 3);
        turn_done = 1; step(); turn_done = 0;
        chk("done_menu", menu, 0); chk("done_cursor", cursor, 0);
        chk("done_code", action_code, 4'b0111);

        // Back then RUN with ready tied high
        press(4'd5); press(4'd0);
        chk("back_menu", menu, 0); chk("back_cursor", cursor, 0);
        action_ready = 1;
        press(4'd8); press(4'd6);
        key_held = 1; key_code = 4'd5; vcnt = 0;
        for (int i = 0; i < 2 * (N + 1); i++) begin
            if (i == N + 1) key_held = 0;
            step();
            if (action_valid) vcnt++;
        end
        chk("run_valid_cycles", vcnt, 1);
        chk("run_menu", menu, 3); chk("run_code", action_code, 4'b0011);
        action_ready = 0;
        turn_done = 1; step(); turn_done = 0;

        // Reset mid-WAIT, key held across reset release
        press(4'd6); press(4'd8); press(4'd5);
        chk("pre_rst_menu", menu, 2);
        key_held = 1; key_code = 4'd6;
        #2 reset = 1; #1;
        model_reset();
        chk("arst_menu", menu, 0); chk("arst_cursor", cursor, 0);
        chk("arst_valid", action_valid, 0); chk("arst_code", action_code, 0);
        @(posedge clk); @(negedge clk); reset = 0;
        repeat (N - 1) step();
        chk("rearm_noevt", dut.w_evt, 0);
        step();
        chk("rearm_evt", dut.w_evt, 1);
        chk("rearm_cursor0", cursor, 0);
        step();
        chk("rearm_cursor1", cursor, 1);
        key_held = 0; repeat (N + 1) step();

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 7);
            key_code = codes[$urandom_range(0, 7)];
            key_held = lvl;
            for (int c = 0; c < len; c++) begin
                action_ready = ($urandom_range(0, 3) == 0);
                turn_done = ($urandom_range(0, 7) == 0);
                step();
            end
        end
        action_ready = 0; turn_done = 0; key_held = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
